// File: rtl/ahb3lite_dma_master_arb.sv
// Shares one AHB3-Lite master port between two requesters.
// The address phase goes to the current grant holder and the data phase to the previous one.
module ahb3lite_dma_master_arb #(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  s0HSEL,
  input  logic [HADDR_SIZE-1:0] s0HADDR,
  input  logic [HDATA_SIZE-1:0] s0HWDATA,
  input  logic                  s0HWRITE,
  input  logic [2:0]            s0HSIZE,
  input  logic [2:0]            s0HBURST,
  input  logic [3:0]            s0HPROT,
  input  logic [1:0]            s0HTRANS,
  output logic                  s0HREADY,
  output logic [HDATA_SIZE-1:0] s0HRDATA,
  output logic                  s0HRESP,
  input  logic                  s1HSEL,
  input  logic [HADDR_SIZE-1:0] s1HADDR,
  input  logic [HDATA_SIZE-1:0] s1HWDATA,
  input  logic                  s1HWRITE,
  input  logic [2:0]            s1HSIZE,
  input  logic [2:0]            s1HBURST,
  input  logic [3:0]            s1HPROT,
  input  logic [1:0]            s1HTRANS,
  output logic                  s1HREADY,
  output logic [HDATA_SIZE-1:0] s1HRDATA,
  output logic                  s1HRESP,
  output logic                  mHSEL,
  output logic [HADDR_SIZE-1:0] mHADDR,
  output logic [HDATA_SIZE-1:0] mHWDATA,
  output logic                  mHWRITE,
  output logic [2:0]            mHSIZE,
  output logic [2:0]            mHBURST,
  output logic [3:0]            mHPROT,
  output logic [1:0]            mHTRANS,
  input  logic [HDATA_SIZE-1:0] mHRDATA,
  input  logic                  mHREADY,
  input  logic                  mHRESP,
  output logic                  mHMASTER
);

  // state | meaning
  // GNT0  | requester 0 owns the address phase
  // GNT1  | requester 1 owns the address phase
  typedef enum logic {GNT0 = 1'b0, GNT1 = 1'b1} gnt_t;

  localparam logic [1:0] HTRANS_IDLE = 2'b00;

  gnt_t r_gnt;
  logic r_dgnt;
  logic w_req0, w_req1, w_own_idle, w_other_req;

  // NONSEQ and SEQ both have HTRANS[1] set; BUSY does not count as a new request
  assign w_req0      = s0HTRANS[1];
  assign w_req1      = s1HTRANS[1];
  assign w_own_idle  = (r_gnt == GNT0) ? (s0HTRANS == HTRANS_IDLE) : (s1HTRANS == HTRANS_IDLE);
  assign w_other_req = (r_gnt == GNT0) ? w_req1 : w_req0;

  // Only an IDLE owner can lose the grant, so bursts and BUSY cycles are never split
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_gnt  <= GNT0;
      r_dgnt <= 1'b0;
    end else if (mHREADY) begin
      r_dgnt <= (r_gnt == GNT1);
      if (w_own_idle && w_other_req)
        r_gnt <= (r_gnt == GNT0) ? GNT1 : GNT0;
    end
  end

  always_comb begin
    mHSEL   = s0HSEL;
    mHADDR  = s0HADDR;
    mHWRITE = s0HWRITE;
    mHSIZE  = s0HSIZE;
    mHBURST = s0HBURST;
    mHPROT  = s0HPROT;
    mHTRANS = s0HTRANS;
    if (r_gnt == GNT1) begin
      mHSEL   = s1HSEL;
      mHADDR  = s1HADDR;
      mHWRITE = s1HWRITE;
      mHSIZE  = s1HSIZE;
      mHBURST = s1HBURST;
      mHPROT  = s1HPROT;
      mHTRANS = s1HTRANS;
    end
    if (rst_i) begin
      mHSEL   = 1'b0;
      mHTRANS = HTRANS_IDLE;
    end
  end

  assign mHMASTER = !rst_i && (r_gnt == GNT1);
  assign mHWDATA  = r_dgnt ? s1HWDATA : s0HWDATA;

  assign s0HRDATA = rst_i ? '0 : mHRDATA;
  assign s1HRDATA = rst_i ? '0 : mHRDATA;
  assign s0HRESP  = !rst_i && !r_dgnt && mHRESP;
  assign s1HRESP  = !rst_i &&  r_dgnt && mHRESP;

  // A stalled non-owner that is idle has nothing pending, so it may see ready
  assign s0HREADY = rst_i ? 1'b1 : (r_gnt == GNT0) ? mHREADY : (s0HTRANS == HTRANS_IDLE);
  assign s1HREADY = rst_i ? 1'b1 : (r_gnt == GNT1) ? mHREADY : (s1HTRANS == HTRANS_IDLE);

endmodule

// File: tb/tb_ahb3lite_dma_master_arb.sv
// Bench for ahb3lite_dma_master_arb: directed scenarios, then random traffic
// compared against a transaction-level ownership model.
module tb_ahb3lite_dma_master_arb;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        s0HSEL, s1HSEL;
  logic [31:0] s0HADDR, s1HADDR, s0HWDATA, s1HWDATA;
  logic        s0HWRITE, s1HWRITE;
  logic [2:0]  s0HSIZE, s1HSIZE, s0HBURST, s1HBURST;
  logic [3:0]  s0HPROT, s1HPROT;
  logic [1:0]  s0HTRANS, s1HTRANS;
  logic        s0HREADY, s1HREADY, s0HRESP, s1HRESP;
  logic [31:0] s0HRDATA, s1HRDATA;
  logic        mHSEL, mHWRITE, mHREADY, mHRESP, mHMASTER;
  logic [31:0] mHADDR, mHWDATA, mHRDATA;
  logic [2:0]  mHSIZE, mHBURST;
  logic [3:0]  mHPROT;
  logic [1:0]  mHTRANS;

  int n_tests = 0;
  int n_fail  = 0;

  ahb3lite_dma_master_arb #(.HADDR_SIZE(32), .HDATA_SIZE(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .s0HSEL(s0HSEL), .s0HADDR(s0HADDR), .s0HWDATA(s0HWDATA), .s0HWRITE(s0HWRITE),
    .s0HSIZE(s0HSIZE), .s0HBURST(s0HBURST), .s0HPROT(s0HPROT), .s0HTRANS(s0HTRANS),
    .s0HREADY(s0HREADY), .s0HRDATA(s0HRDATA), .s0HRESP(s0HRESP),
    .s1HSEL(s1HSEL), .s1HADDR(s1HADDR), .s1HWDATA(s1HWDATA), .s1HWRITE(s1HWRITE),
    .s1HSIZE(s1HSIZE), .s1HBURST(s1HBURST), .s1HPROT(s1HPROT), .s1HTRANS(s1HTRANS),
    .s1HREADY(s1HREADY), .s1HRDATA(s1HRDATA), .s1HRESP(s1HRESP),
    .mHSEL(mHSEL), .mHADDR(mHADDR), .mHWDATA(mHWDATA), .mHWRITE(mHWRITE),
    .mHSIZE(mHSIZE), .mHBURST(mHBURST), .mHPROT(mHPROT), .mHTRANS(mHTRANS),
    .mHRDATA(mHRDATA), .mHREADY(mHREADY), .mHRESP(mHRESP), .mHMASTER(mHMASTER)
  );

  always #5 clk_i = ~clk_i;

  // Inputs change 1 ns after the rising edge; outputs are sampled 2 ns later.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; s1HSEL = 1'b1; s1HTRANS = 2'b10; s1HADDR = 32'h55;
    mHRDATA = 32'hA5A5_A5A5; mHRESP = 1'b1; mHREADY = 1'b1;
    tick(); tick(); #2;
    n_tests++; if (mHTRANS !== 2'b00) begin n_fail++; $display("FAIL rst_mhtrans got %h exp 0", mHTRANS); end
    n_tests++; if (mHSEL !== 1'b0) begin n_fail++; $display("FAIL rst_mhsel got %h exp 0", mHSEL); end
    n_tests++; if (mHMASTER !== 1'b0) begin n_fail++; $display("FAIL rst_mhmaster got %h exp 0", mHMASTER); end
    n_tests++; if ({s0HREADY, s1HREADY} !== 2'b11) begin n_fail++; $display("FAIL rst_hready got %b exp 11", {s0HREADY, s1HREADY}); end
    n_tests++; if ({s0HRESP, s1HRESP} !== 2'b00) begin n_fail++; $display("FAIL rst_hresp got %b exp 00", {s0HRESP, s1HRESP}); end
    n_tests++; if (s0HRDATA !== 32'h0 || s1HRDATA !== 32'h0) begin n_fail++; $display("FAIL rst_hrdata got %h/%h exp 0", s0HRDATA, s1HRDATA); end
    tick();
    rst_i = 1'b0; s1HTRANS = 2'b00; s1HSEL = 1'b0; mHRESP = 1'b0; mHRDATA = 32'h0;
    #2;
    n_tests++; if (mHMASTER !== 1'b0) begin n_fail++; $display("FAIL post_rst_mhmaster got %h exp 0", mHMASTER); end
    tick();
  endtask

  task automatic test_single_read();
    s0HSEL = 1'b1; s0HTRANS = 2'b10; s0HADDR = 32'h100; s0HWRITE = 1'b0; s0HBURST = 3'b000; s0HSIZE = 3'b010;
    #2;
    n_tests++; if (mHADDR !== 32'h100 || mHTRANS !== 2'b10) begin n_fail++; $display("FAIL rd_addr got %h/%h exp 100/2", mHADDR, mHTRANS); end
    n_tests++; if (mHMASTER !== 1'b0 || s0HREADY !== 1'b1) begin n_fail++; $display("FAIL rd_addr_grant got %h/%h exp 0/1", mHMASTER, s0HREADY); end
    tick();
    s0HTRANS = 2'b00; s0HSEL = 1'b0; mHRDATA = 32'hDEAD_BEEF;
    #2;
    n_tests++; if (s0HRDATA !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_data got %h exp deadbeef", s0HRDATA); end
    n_tests++; if (s0HREADY !== 1'b1 || mHMASTER !== 1'b0) begin n_fail++; $display("FAIL rd_data_ready got %h/%h exp 1/0", s0HREADY, mHMASTER); end
    tick();
    mHRDATA = 32'h0;
  endtask

  task automatic test_handover();
    s1HSEL = 1'b1; s1HTRANS = 2'b10; s1HADDR = 32'h200; s1HWRITE = 1'b1; s0HWDATA = 32'hBAD0_BAD0;
    #2;
    n_tests++; if (s1HREADY !== 1'b0 || mHMASTER !== 1'b0) begin n_fail++; $display("FAIL ho_stall got %h/%h exp 0/0", s1HREADY, mHMASTER); end
    tick();
    #2;
    n_tests++; if (mHMASTER !== 1'b1 || mHADDR !== 32'h200) begin n_fail++; $display("FAIL ho_fwd got %h/%h exp 1/200", mHMASTER, mHADDR); end
    n_tests++; if (mHWRITE !== 1'b1 || s1HREADY !== 1'b1) begin n_fail++; $display("FAIL ho_fwd_ctl got %h/%h exp 1/1", mHWRITE, s1HREADY); end
    tick();
    s1HTRANS = 2'b00; s1HSEL = 1'b0; s1HWDATA = 32'h1234_5678;
    #2;
    n_tests++; if (mHWDATA !== 32'h1234_5678) begin n_fail++; $display("FAIL ho_wdata got %h exp 12345678", mHWDATA); end
    tick();
  endtask

  task automatic test_burst_hold();
    // grant is parked on requester 1; requester 0 must win it back first
    s0HSEL = 1'b1; s0HTRANS = 2'b10; s0HADDR = 32'h300; s0HBURST = 3'b011; s0HWRITE = 1'b0;
    #2;
    n_tests++; if (s0HREADY !== 1'b0) begin n_fail++; $display("FAIL bu_reclaim got %h exp 0", s0HREADY); end
    tick();
    s1HSEL = 1'b1; s1HTRANS = 2'b10; s1HADDR = 32'h400;
    for (int b = 0; b < 4; b++) begin
      if (b > 0) begin s0HTRANS = 2'b11; s0HADDR = 32'h300 + 32'(4 * b); end
      #2;
      n_tests++; if (mHADDR !== 32'h300 + 32'(4 * b) || mHMASTER !== 1'b0) begin n_fail++; $display("FAIL bu_beat%0d got %h/%h exp %h/0", b, mHADDR, mHMASTER, 32'h300 + 32'(4 * b)); end
      n_tests++; if (s1HREADY !== 1'b0) begin n_fail++; $display("FAIL bu_stall%0d got %h exp 0", b, s1HREADY); end
      tick();
    end
    s0HTRANS = 2'b00; s0HSEL = 1'b0;
    #2;
    n_tests++; if (mHMASTER !== 1'b0 || s1HREADY !== 1'b0) begin n_fail++; $display("FAIL bu_idle got %h/%h exp 0/0", mHMASTER, s1HREADY); end
    tick();
    #2;
    n_tests++; if (mHMASTER !== 1'b1 || mHADDR !== 32'h400) begin n_fail++; $display("FAIL bu_switch got %h/%h exp 1/400", mHMASTER, mHADDR); end
    tick();
    s1HTRANS = 2'b00; s1HSEL = 1'b0;
    tick();
  endtask

  task automatic test_wait_states();
    s0HSEL = 1'b1; s0HTRANS = 2'b10; s0HADDR = 32'h500;
    tick();
    s0HTRANS = 2'b00; s0HSEL = 1'b0; s1HSEL = 1'b1; s1HTRANS = 2'b10; s1HADDR = 32'h600; mHREADY = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #2;
      n_tests++; if (mHMASTER !== 1'b0 || s1HREADY !== 1'b0) begin n_fail++; $display("FAIL ws_hold%0d got %h/%h exp 0/0", c, mHMASTER, s1HREADY); end
      n_tests++; if (s0HREADY !== 1'b0) begin n_fail++; $display("FAIL ws_owner%0d got %h exp 0", c, s0HREADY); end
      tick();
    end
    mHREADY = 1'b1;
    #2;
    n_tests++; if (mHMASTER !== 1'b0) begin n_fail++; $display("FAIL ws_release got %h exp 0", mHMASTER); end
    tick();
    #2;
    n_tests++; if (mHMASTER !== 1'b1 || mHADDR !== 32'h600) begin n_fail++; $display("FAIL ws_switch got %h/%h exp 1/600", mHMASTER, mHADDR); end
    tick();
    s1HTRANS = 2'b00; s1HSEL = 1'b0;
    tick();
  endtask

  task automatic test_error();
    s0HSEL = 1'b1; s0HTRANS = 2'b10; s0HADDR = 32'h700; s0HWRITE = 1'b1;
    tick();
    #2;
    n_tests++; if (mHMASTER !== 1'b0) begin n_fail++; $display("FAIL er_grant got %h exp 0", mHMASTER); end
    tick();
    s0HTRANS = 2'b00; s0HSEL = 1'b0; s1HSEL = 1'b1; s1HTRANS = 2'b10; s1HADDR = 32'h800;
    mHREADY = 1'b0; mHRESP = 1'b1;
    #2;
    n_tests++; if ({s0HRESP, s0HREADY, s1HRESP} !== 3'b100) begin n_fail++; $display("FAIL er_cycle1 got %b exp 100", {s0HRESP, s0HREADY, s1HRESP}); end
    tick();
    mHREADY = 1'b1;
    #2;
    n_tests++; if ({s0HRESP, s0HREADY, s1HRESP} !== 3'b110) begin n_fail++; $display("FAIL er_cycle2 got %b exp 110", {s0HRESP, s0HREADY, s1HRESP}); end
    tick();
    mHRESP = 1'b0;
    #2;
    n_tests++; if (mHMASTER !== 1'b1 || s1HRESP !== 1'b0) begin n_fail++; $display("FAIL er_switch got %h/%h exp 1/0", mHMASTER, s1HRESP); end
    tick();
    s1HTRANS = 2'b00; s1HSEL = 1'b0;
    tick();
  endtask

  task automatic test_random();
    int          owner, data_owner;
    logic [1:0]  tr [2];
    logic [31:0] ad [2];
    logic [31:0] wd [2];
    logic        rdy [2];
    logic [70:0] exp_v, got_v;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    owner = 0; data_owner = 0;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < 2; i++) begin
        tr[i] = 2'($urandom_range(0, 3));
        ad[i] = $urandom; wd[i] = $urandom;
      end
      s0HTRANS = tr[0]; s1HTRANS = tr[1]; s0HADDR = ad[0]; s1HADDR = ad[1];
      s0HWDATA = wd[0]; s1HWDATA = wd[1];
      mHREADY = ($urandom_range(0, 3) != 0); mHRESP = ($urandom_range(0, 7) == 0);
      #2;
      for (int i = 0; i < 2; i++) rdy[i] = (i == owner) ? mHREADY : (tr[i] == 2'b00);
      exp_v = {owner == 1, ad[owner], wd[data_owner], tr[owner], rdy[0], rdy[1],
               mHRESP && data_owner == 0, mHRESP && data_owner == 1};
      got_v = {mHMASTER, mHADDR, mHWDATA, mHTRANS, s0HREADY, s1HREADY, s0HRESP, s1HRESP};
      n_tests++; if (got_v !== exp_v) begin n_fail++; $display("FAIL rnd_cycle%0d got %h exp %h", c, got_v, exp_v); end
      // ownership moves only on an accepted cycle, and only away from an idle owner
      if (mHREADY) begin
        data_owner = owner;
        if (tr[owner] == 2'b00 && tr[1 - owner] >= 2'b10) owner = 1 - owner;
      end
      tick();
    end
    s0HTRANS = 2'b00; s1HTRANS = 2'b00; mHREADY = 1'b1; mHRESP = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    s0HSEL = 1'b0; s0HADDR = '0; s0HWDATA = '0; s0HWRITE = 1'b0; s0HSIZE = 3'b010; s0HBURST = '0; s0HPROT = 4'h3; s0HTRANS = 2'b00;
    s1HSEL = 1'b0; s1HADDR = '0; s1HWDATA = '0; s1HWRITE = 1'b0; s1HSIZE = 3'b010; s1HBURST = '0; s1HPROT = 4'h3; s1HTRANS = 2'b00;
    mHRDATA = '0; mHREADY = 1'b1; mHRESP = 1'b0;
    test_reset();
    test_single_read();
    test_handover();
    test_burst_hold();
    test_wait_states();
    test_error();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ahb3lite_dma_master_arb.md
# ahb3lite_dma_master_arb

Two-requester AHB3-Lite master-port arbiter that shares one outgoing AHB3-Lite master port between the DMA core's two master interfaces. Each interface reaches this block through its own `wb_to_ahb3lite` bridge. The block grants the address phase to one requester at a time and stalls the other with HREADY low. It tracks data-phase ownership so that HWDATA, HRDATA and HRESP are routed correctly. Requester inputs connect directly to the bridge `mH*` outputs, and the `mH*` side of this block connects to the system interconnect.

## Interface
Parameters:
- HADDR_SIZE, 32, address width.
- HDATA_SIZE, 32, data width.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset; **synchronous, active-high**.
- s0HSEL, s1HSEL  in  1  requester select.
- s0HADDR, s1HADDR  in  HADDR_SIZE  requester address.
- s0HWDATA, s1HWDATA  in  HDATA_SIZE  requester write data.
- s0HWRITE/s1HWRITE  in  1  requester transfer direction.
- s0HSIZE/s1HSIZE  in  3  requester transfer size.
- s0HBURST/s1HBURST  in  3  requester burst type.
- s0HPROT/s1HPROT  in  4  requester protection.
- s0HTRANS/s1HTRANS  in  2  requester transfer type.
- s0HREADY, s1HREADY  out  1  per-requester ready / stall.
- s0HRDATA, s1HRDATA  out  HDATA_SIZE  read data.
- s0HRESP, s1HRESP  out  1  per-requester response.
- mHSEL  out  1  muxed select.
- mHADDR  out  HADDR_SIZE  muxed address.
- mHWDATA  out  HDATA_SIZE  muxed write data.
- mHWRITE  out  1  muxed direction.
- mHSIZE  out  3  muxed size.
- mHBURST  out  3  muxed burst type.
- mHPROT  out  4  muxed protection.
- mHTRANS  out  2  muxed transfer type.
- mHRDATA  in  HDATA_SIZE  slave read data.
- mHREADY  in  1  slave ready.
- mHRESP  in  1  slave response.
- mHMASTER  out  1  current address-phase grant (0/1).

## Operation
- State:
  - `gnt`: address-phase owner, encoded as GNT0/GNT1.
  - `dgnt`: data-phase owner.
- Request definition: requester i requests when sIHTRANS is NONSEQ or SEQ.
  - BUSY from the owner counts as holding the grant.
- Address mux:
  - mHSEL, mHADDR, mHWRITE, mHSIZE, mHBURST, mHPROT and mHTRANS are taken combinationally from the requester selected by `gnt`.
- Data mux:
  - mHWDATA is taken from `dgnt`.
  - sIHRDATA = mHRDATA for both requesters (broadcast).
  - sIHRESP = mHRESP when dgnt==i, else 0.
- Ready rules:
  - Owner (i==gnt): sIHREADY = mHREADY.
  - Non-owner: sIHREADY = 1 if sIHTRANS==IDLE, else 0. The requester holds its address phase until granted.
- Grant FSM (GNT0 <-> GNT1):
  - Evaluated only at a rising edge where mHREADY=1.
  - Switch when the owner's HTRANS==IDLE and the other requester requests.
  - Otherwise hold. With no requests, the grant parks on the last owner.
- No switch mid-burst:
  - SEQ or BUSY from the owner always holds the grant.
  - A non-SINGLE burst owner keeps the grant until it drives IDLE.
  - Requesters must insert IDLE to release the port; the bridges do this between classic cycles.
- Data owner update: `dgnt <= gnt` at every edge with mHREADY=1; otherwise hold.
- Handover invariant:
  - A switch happens only after the owner's IDLE is accepted, so the old owner never has a live data phase after it loses the grant.
  - Its previous data phase completes at the same edge as the switch.
- ERROR response:
  - The two-cycle ERROR is routed to `dgnt`.
  - If the owner cancels with IDLE during ERROR, the grant may switch at the second ERROR cycle's edge (mHREADY=1).

## Timing
- Reset (rst_i high at an edge):
  - gnt=GNT0, dgnt=0.
- While rst_i is high:
  - mHTRANS=IDLE, mHSEL=0, mHMASTER=0.
  - s0HREADY=s1HREADY=1.
  - s0HRESP=s1HRESP=0, s0HRDATA=s1HRDATA=0.
- Reset mid-transfer: the in-flight transfer is abandoned; the slave shares rst_i.
- Latency, owner: zero added cycles; the address is presented in the same cycle it is driven.
- Latency, handover:
  - A non-owner request seen at edge N (owner IDLE, mHREADY=1) is forwarded in cycle N+1.
  - Its address is accepted at the first subsequent edge with mHREADY=1.
  - There is at least one stall cycle on the non-owner (sIHREADY=0).
- Wait states:
  - mHREADY=0 freezes `gnt` and `dgnt`, whatever the requests are.
  - The owner sees the wait state.
- Simultaneous events: the owner driving IDLE while the other requests at the same edge with mHREADY=1 switches the grant at that edge.

## Test plan
- Reset: rst_i=1 for 2 cycles with s1HTRANS=NONSEQ -> mHTRANS=0, mHMASTER=0, s0HREADY=s1HREADY=1, s0HRESP=0.
- Single read: s0 NONSEQ SINGLE read, addr 0x100; slave returns 0xDEADBEEF -> mHADDR=0x100 in the same cycle; s0HRDATA=0xDEADBEEF with s0HREADY=1 in the data phase; mHMASTER stays 0.
- Handover from parked grant: grant=0 and s0 idle; s1 NONSEQ write, addr 0x200, data 0x12345678 -> s1HREADY=0 in cycle N; mHMASTER=1 and mHADDR=0x200 in N+1; mHWDATA=0x12345678 in N+2.
- Burst hold: s0 INCR4 at 0x300 while s1 requests -> s1HREADY=0 for all 4 beats; mHADDR goes 0x300..0x30C; s1 is forwarded only after s0 drives IDLE.
- Wait states: mHREADY=0 for 3 cycles with s0 owner IDLE and s1 requesting -> mHMASTER stays 0; it switches at the first edge with mHREADY=1.
- Error routing: slave ERROR on s0 write -> s0HRESP=1 for 2 cycles, s0HREADY=0 then 1; s1HRESP=0 throughout.
